// File: rtl/cp0.sv
// cp0 -- Coprocessor 0 for the P8 MIPS core.
//
// Holds SR (12), Cause (13), EPC (14) and the read-only PRId (15).
// Combines the live hardware interrupt levels with the M-stage internal
// exception request into a single IntReq for the pipeline controller.
// It also supplies EPC for eret and serves mfc0 reads and mtc0 writes.
//
// Ports
//   CLK, RST   clock; synchronous active-high reset
//   RA / RD    mfc0 register number / combinational read data
//   WA, WE, WD mtc0 register number, write enable, write data
//   PC, BDIn   victim PC and its branch-delay-slot flag
//   ExcReq, ExcCodeIn  internal exception request and its code
//   HWInt      interrupt levels: [0] Timer0, [1] Timer1, [2] external
//   EXLClr     eret in M stage
//   IntReq     take exception this cycle (combinational)
//   EPCOut     current EPC
module cp0 #(
  parameter logic [31:0] PRID = 32'h5038_0008
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RA,
  input  logic [4:0]  WA,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic        ExcReq,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Only the architecturally defined fields are stored; every other bit
  // reads back as zero.
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupts are judged on the live HWInt lines, not on the IP copy, so
  // the request never lags its cause.
  assign int_pend = (|(HWInt & im)) & ie & ~exl;
  assign exc_pend = ExcReq & ~exl;
  assign IntReq   = int_pend | exc_pend;

  // A victim in a delay slot resumes at the branch, one word earlier.
  assign victim_pc = BDIn ? ({PC[31:2], 2'b00} - 32'd4) : {PC[31:2], 2'b00};

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
  assign EPCOut     = epc;

  // NOTE: a combinational block assigns its output on every path (default
  // first) so no latch is inferred.
  always_comb begin
    RD = 32'd0;
    case (RA)
      REG_SR:    RD = sr_word;
      REG_CAUSE: RD = cause_word;
      REG_EPC:   RD = epc;
      REG_PRID:  RD = PRID;
      default:   RD = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      im       <= 6'd0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'd0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        // Exception entry discards any mtc0 issued by the victim.
        exl      <= 1'b1;
        bd       <= BDIn;
        exc_code <= int_pend ? 5'd0 : ExcCodeIn;
        epc      <= victim_pc;
      end else begin
        if (WE && WA == REG_SR) begin
          im  <= WD[15:10];
          exl <= WD[1];
          ie  <= WD[0];
        end
        if (WE && WA == REG_EPC) begin
          epc <= {WD[31:2], 2'b00};
        end
        // Placed after the SR write so eret wins over a written EXL bit.
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0 -- self-checking bench for cp0.
//
// A word-level model of SR/Cause/EPC runs alongside the DUT; a compare
// process checks IntReq, EPCOut and RD against it on every falling edge
// once reset has been applied. Directed steps add hand-computed literal
// expectations that pin the model itself.
module tb_cp0;

  localparam logic [31:0] PRID_VAL = 32'h5038_0008;
  localparam logic [31:0] SR_MASK  = 32'h0000_FC03;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RA;
  logic [4:0]  WA;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [31:0] PC;
  logic        BDIn;
  logic        ExcReq;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;

  int n_cmp = 0;
  int n_bad = 0;

  cp0 dut (
    .CLK(CLK), .RST(RST), .RA(RA), .WA(WA), .WE(WE), .WD(WD), .RD(RD),
    .PC(PC), .BDIn(BDIn), .ExcReq(ExcReq), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPCOut(EPCOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (whole-register words) -------------
  logic [31:0] m_sr, m_cause, m_epc;
  bit          m_ready = 0;

  function automatic bit m_int_pend();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_intreq();
    return m_int_pend() || (ExcReq && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] ra);
    case (ra)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
      m_ready = 1;
    end else if (m_ready) begin
      if (m_intreq()) begin
        logic [31:0] code;
        code    = m_int_pend() ? 32'd0 : 32'(ExcCodeIn);
        m_cause = (32'(BDIn) << 31) | (32'(HWInt) << 10) | (code << 2);
        m_epc   = (PC & ~32'd3) - (BDIn ? 32'd4 : 32'd0);
        m_sr    = m_sr | 32'd2;
      end else begin
        m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
        if (WE && WA == 5'd12) m_sr = WD & SR_MASK;
        if (WE && WA == 5'd14) m_epc = WD & ~32'd3;
        if (EXLClr) m_sr = m_sr & ~32'd2;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_ready && !RST) begin
      check("model_intreq", 32'(IntReq), 32'(m_intreq()));
      check("model_epcout", EPCOut, m_epc);
      check("model_rd", RD, m_rd(RA));
    end
  end

  // ---------------- directed stimulus ------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] ra, input logic [31:0] exp);
    RA = ra;
    #1;
    check(name, RD, exp);
  endtask

  task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
    WE = 1'b1; WA = wa; WD = wd;
    step();
    WE = 1'b0;
  endtask

  initial begin
    RST = 1'b1; RA = 5'd0; WA = 5'd0; WE = 1'b0; WD = 32'd0; PC = 32'd0;
    BDIn = 1'b0; ExcReq = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    #2;
    step();
    RST = 1'b0;

    // Reset state
    rd_chk("reset_prid", 5'd15, PRID_VAL);
    check("reset_intreq", 32'(IntReq), 32'd0);
    check("reset_epc", EPCOut, 32'd0);
    rd_chk("reset_sr", 5'd12, 32'd0);
    rd_chk("reset_cause", 5'd13, 32'd0);
    rd_chk("reset_other", 5'd3, 32'd0);

    // Timer interrupt
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010; BDIn = 1'b0;
    #1 check("timer_intreq", 32'(IntReq), 32'd1);
    step();
    check("timer_epc", EPCOut, 32'h0000_3010);
    check("timer_intreq_held", 32'(IntReq), 32'd0);
    rd_chk("timer_sr", 5'd12, 32'h0000_0403);
    rd_chk("timer_cause", 5'd13, 32'h0000_0400);
    HWInt = 6'd0; EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    rd_chk("eret_sr", 5'd12, 32'h0000_0401);

    // Delay slot plus interrupt-over-exception priority
    mtc0(5'd12, 32'h0000_0801);
    HWInt = 6'b000010; ExcReq = 1'b1; ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
    #1 check("bd_intreq", 32'(IntReq), 32'd1);
    step();
    HWInt = 6'd0; ExcReq = 1'b0; BDIn = 1'b0;
    check("bd_epc", EPCOut, 32'h0000_3020);
    rd_chk("bd_cause", 5'd13, 32'h8000_0800);

    // Internal exception with interrupts disabled
    mtc0(5'd12, 32'd0);
    ExcReq = 1'b1; ExcCodeIn = 5'd10; PC = 32'h0000_3100;
    #1 check("exc_intreq", 32'(IntReq), 32'd1);
    step();
    ExcCodeIn = 5'd4;
    check("exc_epc", EPCOut, 32'h0000_3100);
    check("exc_second_blocked", 32'(IntReq), 32'd0);
    rd_chk("exc_sr", 5'd12, 32'h0000_0002);
    rd_chk("exc_cause", 5'd13, 32'h0000_0028);
    step();
    ExcReq = 1'b0;
    check("exc_epc_kept", EPCOut, 32'h0000_3100);

    // eret with simultaneous SR write, EPC write, Cause write ignored
    EXLClr = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    EXLClr = 1'b0;
    rd_chk("eret_write_sr", 5'd12, 32'h0000_0401);
    WE = 1'b1; WA = 5'd14; WD = 32'h0000_3007;
    rd_chk("epc_no_bypass", 5'd14, 32'h0000_3100);
    step();
    WE = 1'b0;
    check("epc_write", EPCOut, 32'h0000_3004);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd_chk("cause_ro", 5'd13, 32'h0000_0028);
    mtc0(5'd15, 32'h1234_5678);
    rd_chk("prid_ro", 5'd15, PRID_VAL);

    // Unmasking an already-pending line raises IntReq the next cycle
    HWInt = 6'b000100; PC = 32'h0000_3200;
    #1 check("ext_masked", 32'(IntReq), 32'd0);
    mtc0(5'd12, 32'h0000_1001);
    check("ext_unmasked", 32'(IntReq), 32'd1);
    step();
    HWInt = 6'd0;
    check("ext_epc", EPCOut, 32'h0000_3200);
    rd_chk("ext_cause", 5'd13, 32'h0000_1000);

    // Mask: IM=0, IE=1; IP still tracks HWInt
    EXLClr = 1'b1;
    mtc0(5'd12, 32'h0000_0001);
    EXLClr = 1'b0;
    HWInt = 6'b000111;
    #1 check("mask_intreq", 32'(IntReq), 32'd0);
    step();
    check("mask_intreq_next", 32'(IntReq), 32'd0);
    rd_chk("mask_ip", 5'd13, 32'h0000_1C00);

    // Reset in the middle of an exception request
    ExcReq = 1'b1; PC = 32'h0000_4000; RST = 1'b1;
    step();
    RST = 1'b0; ExcReq = 1'b0;
    check("rst_mid_epc", EPCOut, 32'd0);
    rd_chk("rst_mid_sr", 5'd12, 32'd0);
    rd_chk("rst_mid_cause", 5'd13, 32'd0);

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 block for the P8 MIPS core: holds SR (12), Cause (13), EPC (14) and PRId (15), and consumes the level-sensitive IRQ lines from the two Timers and the external device. It combines the pending interrupts with the M-stage internal exception request and raises a single IntReq to the pipeline controller. It also provides EPC for `eret` and serves `mfc0`/`mtc0`.

## Interface
- PRID, 32'h5038_0008, constant value returned when reading register 15
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- RA  in  5  mfc0 register number
- WA  in  5  mtc0 register number
- WE  in  1  mtc0 write enable (M stage)
- WD  in  32  mtc0 write data
- RD  out  32  mfc0 read data, combinational
- PC  in  32  PC of the M-stage instruction (the victim)
- BDIn  in  1  victim instruction is in a branch delay slot
- ExcReq  in  1  internal exception present in M stage
- ExcCodeIn  in  5  code of that exception (AdEL 4, AdES 5, RI 10, Ov 12)
- HWInt  in  6  hardware interrupt levels; [0] Timer0 IRQ, [1] Timer1 IRQ, [2] external, [5:3] tied 0
- EXLClr  in  1  `eret` in M stage
- IntReq  out  1  take exception this cycle, combinational
- EPCOut  out  32  current EPC register

## Operation
- SR fields:
  - IM = SR[15:10]; EXL = SR[1]; IE = SR[0].
  - All other bits read 0.
  - mtc0 to 12 writes only IM, EXL, IE.
- Cause fields:
  - BD = Cause[31]; IP = Cause[15:10]; ExcCode = Cause[6:2].
  - Other bits read 0.
  - mtc0 to 13 is ignored.
- EPC: mtc0 to 14 stores {WD[31:2], 2'b00}.
- PRId: read-only; writes ignored.
- RD:
  - Register 12/13/14/15 → that register's current value.
  - Any other RA → 0.
  - No bypass: a read in the same cycle as a write returns the old value.
- IP update: IP <= HWInt every cycle, unconditionally. This includes while EXL=1 and on the cycle IntReq is asserted.
- Request logic:
  - IntPend = |(HWInt & IM) & IE & ~EXL, computed from live HWInt, not IP.
  - ExcPend = ExcReq & ~EXL.
  - IntReq = IntPend | ExcPend.
- Priority: an interrupt wins over a simultaneous internal exception (ExcCode = 0).
- On a posedge with IntReq=1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntPend ? 0 : ExcCodeIn.
  - EPC <= BDIn ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
  - Any mtc0 in the same cycle is discarded entirely.
- On a posedge with EXLClr=1 (and IntReq=0): EXL <= 0. If WE writes SR in the same cycle, IM/IE take WD while EXL is forced 0.
- IntReq and EXLClr together cannot occur legally, since `eret` runs with EXL=1. If it happens anyway, IntReq takes priority.
- Timer IRQ is a held level. Clearing it is the handler's job via the Timer registers; cp0 does not acknowledge or latch it.

## Timing
- Reset values (registers cleared on the posedge where RST=1):
  - SR = 0, Cause = 0, EPC = 0.
  - Hence IntReq = 0 and EPCOut = 0 after reset.
  - RD = 0 for RA ∉ {12,13,14,15}; RD = PRID for RA = 15.
- RST mid-exception: all register updates that cycle are dropped; reset values win.
- IntReq is combinational, same cycle as its causes. Register effects are visible the cycle after.
- mtc0 write: visible on RD and in IntReq one cycle after WE.
  - Example: enabling IE with an already-pending masked-in HWInt raises IntReq on the next cycle.
- IP lags HWInt by one cycle. IntReq does not lag.
- EPCOut reflects EPC with zero additional latency after the update edge.

## Test plan
1. **Reset:** RST=1 for 1 cycle → SR=0, Cause=0, EPC=0, IntReq=0; RA=15 → RD=PRID.
2. **Timer interrupt:**
   - Stimulus: mtc0 SR ← 0x0000_0401, then HWInt=6'b000001, PC=0x0000_3010, BDIn=0.
   - IntReq=1 that cycle.
   - Next cycle: EPC=0x3010, SR=0x0403, Cause=0x0000_0400, IntReq=0 even with HWInt held.
3. **Delay slot plus priority:**
   - Stimulus: IE=1, IM[1]=1, HWInt[1]=1, ExcReq=1 with ExcCodeIn=12, BDIn=1, PC=0x3024.
   - Required: EPC=0x3020, Cause[31]=1, ExcCode=0.
4. **Internal exception with interrupts disabled:**
   - Stimulus: SR=0, ExcReq=1, ExcCodeIn=10, PC=0x3100.
   - Required: IntReq=1, then ExcCode=10, EPC=0x3100, EXL=1. A second ExcReq while EXL=1 → IntReq=0.
5. **eret plus writes:**
   - Stimulus: EXLClr=1 with mtc0 SR ← 0x0000_0403.
   - Required next cycle: SR=0x0401.
   - mtc0 EPC ← 0x3007 → EPCOut=0x3004.
   - mtc0 to 13 → Cause unchanged.
6. **Mask:** IM=0, IE=1, HWInt=6'b000111 → IntReq=0 while IP reads 0x0000_1C00 one cycle later.
